// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared constants and helpers for the transmit-side parity generator.
//   PAR_EVEN / PAR_ODD : parity sense selector values
//   FIFO_DEPTH         : number of buffered words between master and link
//   BYTE_W             : bits covered by one parity bit
//   nbytes()           : number of parity bits for a given data width
//   byte_parity()      : parity of one byte under the selected sense
// -----------------------------------------------------------------------------
package parity_pkg;

   localparam logic PAR_EVEN   = 1'b0;
   localparam logic PAR_ODD    = 1'b1;
   localparam int   FIFO_DEPTH = 32'sd2;
   localparam int   BYTE_W     = 32'sd8;

   function automatic int nbytes(input int width);
      return width / BYTE_W;
   endfunction

   // Even sense returns the XOR of the byte; odd sense returns its inverse.
   function automatic logic byte_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/parity_byte_calc.sv
// -----------------------------------------------------------------------------
// parity_byte_calc
// Purely combinational parity of one byte.
//   data : byte to protect
//   odd  : 0 = even parity, 1 = odd parity
//   par  : resulting parity bit
// -----------------------------------------------------------------------------
module parity_byte_calc
   import parity_pkg::*;
(
   input  logic [7:0] data,
   input  logic       odd,
   output logic       par
);

   assign par = byte_parity(data, odd);

endmodule

// File: rtl/parity_gen.sv
// -----------------------------------------------------------------------------
// parity_gen
// Transmit-side parity generator. Words accepted on the input stream get
// per-byte and whole-word parity attached and are forwarded through a
// 2-entry FIFO. chk_en strobes the downstream comparator on every transfer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready is registered)
//   in_data             : input word
//   out_valid/out_ready : output handshake
//   out_data            : forwarded word
//   out_par             : per-byte parity, bit i covers byte i
//   out_word_par        : parity over the whole word
//   chk_en              : out_valid & out_ready
// Optional build macro PARITY_GEN_INJECT_EN adds inj_req / inj_mask, a
// one-shot fault-injection arm that corrupts the parity of the next pushed
// word. Without the macro the ports and logic are absent.
// -----------------------------------------------------------------------------
module parity_gen
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit ODD        = 1'b0
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [nbytes(DATA_WIDTH)-1:0]   out_par,
   output logic                            out_word_par,
   output logic                            chk_en
`ifdef PARITY_GEN_INJECT_EN
   ,
   input  logic                            inj_req,
   input  logic [nbytes(DATA_WIDTH)-1:0]   inj_mask
`endif
);

   localparam int         NB      = nbytes(DATA_WIDTH);
   localparam logic       ODD_BIT = ODD ? PAR_ODD : PAR_EVEN;
   localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

   // FIFO storage and pointers
   logic [DATA_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
   logic [NB-1:0]         mem_par_r  [FIFO_DEPTH];
   logic                  mem_wpar_r [FIFO_DEPTH];
   logic                  head_r;
   logic                  tail_r;
   logic [1:0]            count_r;

   // Registered outputs
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic [NB-1:0]         out_par_r;
   logic                  out_word_par_r;

   // Combinational helpers
   logic                  push_s;
   logic                  pop_s;
   logic [1:0]            count_next_s;
   logic [1:0]            remain_s;
   logic                  head_next_s;
   logic [NB-1:0]         byte_par_s;
   logic                  word_par_s;
   logic [NB-1:0]         push_par_s;
   logic                  push_wpar_s;
   logic [DATA_WIDTH-1:0] head_data_s;
   logic [NB-1:0]         head_par_s;
   logic                  head_wpar_s;

   assign push_s = in_valid & in_ready_r;
   assign pop_s  = out_valid_r & out_ready;

   for (genvar i = 0; i < NB; i++) begin : g_byte
      parity_byte_calc u_calc (
         .data (in_data[BYTE_W*i +: BYTE_W]),
         .odd  (ODD_BIT),
         .par  (byte_par_s[i])
      );
   end

   assign word_par_s = (^in_data) ^ ODD_BIT;

`ifdef PARITY_GEN_INJECT_EN
   logic          arm_r;
   logic [NB-1:0] mask_r;
   logic          inj_active_s;
   logic [NB-1:0] inj_mask_s;

   // A request in the same cycle as a push overrides the stored arm/mask.
   always_comb begin
      inj_active_s = arm_r | inj_req;
      if (inj_req) begin
         inj_mask_s = inj_mask;
      end else begin
         inj_mask_s = mask_r;
      end
   end

   // Apply the injection mask to the parity being written.
   always_comb begin
      push_par_s  = byte_par_s;
      push_wpar_s = word_par_s;
      if (inj_active_s) begin
         push_par_s  = byte_par_s ^ inj_mask_s;
         push_wpar_s = word_par_s ^ (^inj_mask_s);
      end else begin
         push_par_s  = byte_par_s;
         push_wpar_s = word_par_s;
      end
   end

   // One-shot arm: set by a request, consumed by the next push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_r  <= 1'b0;
         mask_r <= {NB{1'b0}};
      end else if (push_s) begin
         arm_r  <= 1'b0;
      end else if (inj_req) begin
         arm_r  <= 1'b1;
         mask_r <= inj_mask;
      end
   end
`else
   assign push_par_s  = byte_par_s;
   assign push_wpar_s = word_par_s;
`endif

   // Next occupancy and head pointer.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + 2'd1;
         2'b01:   count_next_s = count_r - 2'd1;
         default: count_next_s = count_r;
      endcase
      head_next_s = head_r;
      if (pop_s) begin
         head_next_s = ~head_r;
      end else begin
         head_next_s = head_r;
      end
   end

   // Entry that will sit at the head after this edge; when the FIFO drains to
   // empty in the same cycle as a push, that is the word being written now.
   always_comb begin
      remain_s    = count_r - {1'b0, pop_s};
      head_data_s = mem_data_r[head_next_s];
      head_par_s  = mem_par_r[head_next_s];
      head_wpar_s = mem_wpar_r[head_next_s];
      if (push_s && (remain_s == 2'd0)) begin
         head_data_s = in_data;
         head_par_s  = push_par_s;
         head_wpar_s = push_wpar_s;
      end else begin
         head_data_s = mem_data_r[head_next_s];
         head_par_s  = mem_par_r[head_next_s];
         head_wpar_s = mem_wpar_r[head_next_s];
      end
   end

   // FIFO storage write on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_r[i] <= {DATA_WIDTH{1'b0}};
            mem_par_r[i]  <= {NB{1'b0}};
            mem_wpar_r[i] <= 1'b0;
         end
      end else if (push_s) begin
         mem_data_r[tail_r] <= in_data;
         mem_par_r[tail_r]  <= push_par_s;
         mem_wpar_r[tail_r] <= push_wpar_s;
      end
   end

   // Pointers, occupancy and registered handshake/output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r         <= 1'b0;
         tail_r         <= 1'b0;
         count_r        <= 2'd0;
         in_ready_r     <= 1'b1;
         out_valid_r    <= 1'b0;
         out_data_r     <= {DATA_WIDTH{1'b0}};
         out_par_r      <= {NB{1'b0}};
         out_word_par_r <= 1'b0;
      end else begin
         head_r      <= head_next_s;
         tail_r      <= push_s ? ~tail_r : tail_r;
         count_r     <= count_next_s;
         in_ready_r  <= (count_next_s < DEPTH_C);
         out_valid_r <= (count_next_s != 2'd0);
         // Hold the last popped entry while empty.
         if (count_next_s != 2'd0) begin
            out_data_r     <= head_data_s;
            out_par_r      <= head_par_s;
            out_word_par_r <= head_wpar_s;
         end
      end
   end

   assign in_ready     = in_ready_r;
   assign out_valid    = out_valid_r;
   assign out_data     = out_data_r;
   assign out_par      = out_par_r;
   assign out_word_par = out_word_par_r;
   assign chk_en       = out_valid_r & out_ready;

endmodule

// File: tb/tb_parity_gen.sv
// -----------------------------------------------------------------------------
// tb_parity_gen
// Directed bench for parity_gen. Two instances share the stimulus: one with
// even parity and one with odd parity. Injection checks are compiled in when
// PARITY_GEN_INJECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_parity_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        out_ready = 1'b0;

   logic        e_in_ready, e_out_valid, e_out_word_par, e_chk_en;
   logic [31:0] e_out_data;
   logic [3:0]  e_out_par;
   logic        o_in_ready, o_out_valid, o_out_word_par, o_chk_en;
   logic [31:0] o_out_data;
   logic [3:0]  o_out_par;

`ifdef PARITY_GEN_INJECT_EN
   logic        inj_req = 1'b0;
   logic [3:0]  inj_mask = 4'h0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   parity_gen #(.DATA_WIDTH(32), .ODD(1'b0)) u_even (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(e_in_ready), .in_data(in_data),
      .out_valid(e_out_valid), .out_ready(out_ready), .out_data(e_out_data),
      .out_par(e_out_par), .out_word_par(e_out_word_par), .chk_en(e_chk_en)
`ifdef PARITY_GEN_INJECT_EN
      , .inj_req(inj_req), .inj_mask(inj_mask)
`endif
   );

   parity_gen #(.DATA_WIDTH(32), .ODD(1'b1)) u_odd (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
      .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
      .out_par(o_out_par), .out_word_par(o_out_word_par), .chk_en(o_chk_en)
`ifdef PARITY_GEN_INJECT_EN
      , .inj_req(inj_req), .inj_mask(inj_mask)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_out_valid", 32'(e_out_valid), 32'd0);
      chk("rst_in_ready", 32'(e_in_ready), 32'd1);
      chk("rst_out_data", e_out_data, 32'd0);
      chk("rst_out_par", 32'(e_out_par), 32'd0);
      chk("rst_word_par", 32'(e_out_word_par), 32'd0);
      chk("rst_chk_en", 32'(e_chk_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // 1/2: single word 0x0000_0001, then 0xFF00_0001
      in_valid = 1'b1; in_data = 32'h0000_0001; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_out_valid", 32'(e_out_valid), 32'd1);
      chk("t1_out_data", e_out_data, 32'h0000_0001);
      chk("t1_even_par", 32'(e_out_par), 32'h1);
      chk("t1_even_wpar", 32'(e_out_word_par), 32'd1);
      chk("t1_chk_en", 32'(e_chk_en), 32'd1);
      chk("t1_odd_par", 32'(o_out_par), 32'hE);
      chk("t1_odd_wpar", 32'(o_out_word_par), 32'd0);
      step();
      chk("t1_drained", 32'(e_out_valid), 32'd0);
      chk("t1_chk_en_low", 32'(e_chk_en), 32'd0);
      chk("t1_hold_last", e_out_data, 32'h0000_0001);

      in_valid = 1'b1; in_data = 32'hFF00_0001;
      step();
      in_valid = 1'b0;
      chk("t2_odd_par", 32'(o_out_par), 32'hE);
      chk("t2_odd_wpar", 32'(o_out_word_par), 32'd0);
      chk("t2_even_par", 32'(e_out_par), 32'h1);
      chk("t2_even_wpar", 32'(e_out_word_par), 32'd1);
      step();

      // 3: backpressure, A/B accepted, C stalled then delivered in order
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h0000_0003;            // A
      step();
      chk("t3_rdy_after_a", 32'(e_in_ready), 32'd1);
      in_data = 32'h0100_0000;                             // B
      step();
      chk("t3_full_rdy", 32'(e_in_ready), 32'd0);
      chk("t3_head_a", e_out_data, 32'h0000_0003);
      in_data = 32'h8080_8080;                             // C, must stall
      step();
      chk("t3_stall_rdy", 32'(e_in_ready), 32'd0);
      chk("t3_hold_a", e_out_data, 32'h0000_0003);
      chk("t3_hold_par", 32'(e_out_par), 32'h0);
      chk("t3_hold_chk", 32'(e_chk_en), 32'd0);
      out_ready = 1'b1;
      step();                                              // pop A
      chk("t3_head_b", e_out_data, 32'h0100_0000);
      chk("t3_b_par", 32'(e_out_par), 32'h8);
      chk("t3_b_wpar", 32'(e_out_word_par), 32'd1);
      chk("t3_rdy_back", 32'(e_in_ready), 32'd1);
      step();                                              // pop B, push C
      in_valid = 1'b0;
      chk("t3_head_c", e_out_data, 32'h8080_8080);
      chk("t3_c_par", 32'(e_out_par), 32'hF);
      chk("t3_c_wpar", 32'(e_out_word_par), 32'd0);
      step();                                              // pop C
      chk("t3_empty", 32'(e_out_valid), 32'd0);

      // 4: occupancy 1 with push and pop every cycle
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA5A5_0000;
      step();
      chk("t4_d0", e_out_data, 32'hA5A5_0000);
      chk("t4_d0_par", 32'(e_out_par), 32'h0);
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_data = 32'h1 << (3 * i);
         step();
         chk($sformatf("t4_data_%0d", i), e_out_data, 32'h1 << (3 * i));
         chk($sformatf("t4_par_%0d", i), 32'(e_out_par), 32'h1 << ((3 * i) / 8));
         chk($sformatf("t4_rdy_%0d", i), 32'(e_in_ready), 32'd1);
         chk($sformatf("t4_vld_%0d", i), 32'(e_out_valid), 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("t4_empty", 32'(e_out_valid), 32'd0);

      // 5: reset with two entries buffered
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1234_5678;
      step();
      in_data = 32'h9ABC_DEF0;
      step();
      in_valid = 1'b0;
      chk("t5_full", 32'(e_in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(e_out_valid), 32'd0);
      chk("t5_rst_ready", 32'(e_in_ready), 32'd1);
      chk("t5_rst_data", e_out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      chk("t5_no_stale", 32'(e_out_valid), 32'd0);
      chk("t5_no_chk", 32'(e_chk_en), 32'd0);

`ifdef PARITY_GEN_INJECT_EN
      // 6: one-shot parity injection
      inj_req = 1'b1; inj_mask = 4'b0100;
      step();
      inj_req = 1'b0; inj_mask = 4'b0000;
      in_valid = 1'b1; in_data = 32'h0;
      step();
      chk("t6_inj_par", 32'(e_out_par), 32'h4);
      chk("t6_inj_wpar", 32'(e_out_word_par), 32'd1);
      chk("t6_inj_odd_par", 32'(o_out_par), 32'hB);
      chk("t6_inj_odd_wpar", 32'(o_out_word_par), 32'd0);
      step();
      chk("t6_oneshot_par", 32'(e_out_par), 32'h0);
      chk("t6_oneshot_wpar", 32'(e_out_word_par), 32'd0);
      inj_req = 1'b1; inj_mask = 4'b0011;                  // same cycle as push
      step();
      inj_req = 1'b0; inj_mask = 4'b0000;
      chk("t6_same_par", 32'(e_out_par), 32'h3);
      chk("t6_same_wpar", 32'(e_out_word_par), 32'd0);
      in_valid = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
